// File: rtl/io_target.sv
// Responder on the multiplexed IO bus: ALE-decoded register bank (RW control regs + sticky status), zero wait states.
// Read drive is combinational in the data phase; build with IOT_READ_CLEAR_EN for read-to-clear status (default W1C).
module io_target #(
    parameter logic [19:0] BASE_ADDR = 20'hF0000,
    parameter int          ADDR_BITS = 3,
    parameter logic        PIO_SPACE = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [15:0]                       bus_in,
    input  logic [3:0]                        adr_hi,
    input  logic                              ale_n,
    input  logic                              oe,
    input  logic                              we,
    input  logic                              pio,
    output logic [15:0]                       bus_out,
    output logic                              bus_drv,
    output logic [16*(2**ADDR_BITS-1)-1:0]    ctrl,
    output logic [2**ADDR_BITS-2:0]           wr_stb,
    input  logic [15:0]                       status_set,
    output logic                              irq
);

    localparam int NREG  = 2**ADDR_BITS;
    localparam int NCTRL = NREG - 1;
    localparam logic [ADDR_BITS-1:0] STAT_IDX = ADDR_BITS'(NCTRL);

    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT} state_t;

    state_t                 state, state_nxt;
    logic                   ale_q;
    logic [ADDR_BITS-1:0]   idx_q, idx_nxt;
    logic [15:0]            ctrl_r [NCTRL];
    logic [15:0]            status;
    logic [15:0]            status_nxt;
    logic [15:0]            clr;
    logic [15:0]            rd_dat;
    logic [19:0]            adr;
    logic                   addr_phase;
    logic                   hit;
    logic                   wr_cyc;
    logic                   rd_cyc;
    logic                   stat_sel;

    assign adr        = {adr_hi, bus_in};
    assign addr_phase = ale_q && !ale_n;
    assign hit        = (adr[19:ADDR_BITS] == BASE_ADDR[19:ADDR_BITS]) && (pio == PIO_SPACE);
    assign wr_cyc     = (state == ACTIVE) && we;
    assign rd_cyc     = (state == ACTIVE) && oe && !we;
    assign stat_sel   = (idx_q == STAT_IDX);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        case (state)
            IDLE: begin
                if (addr_phase) begin
                    idx_nxt   = adr[ADDR_BITS-1:0];
                    state_nxt = hit ? ACTIVE : WAIT;
                end
            end
            ACTIVE: begin
                // A strobe completes the data phase; ALE rising without one aborts it.
                if (we || oe) begin
                    state_nxt = WAIT;
                end else if (ale_n) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (ale_n) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ale_q <= 1'b1;
            idx_q <= '0;
        end else begin
            state <= state_nxt;
            ale_q <= ale_n;
            idx_q <= idx_nxt;
        end
    end

    always_comb begin
        clr = '0;
`ifdef IOT_READ_CLEAR_EN
        if (rd_cyc && stat_sel) begin
            clr = status;
        end
`else
        if (wr_cyc && stat_sel) begin
            clr = bus_in;
        end
`endif
        // Set is OR-ed after the clear so a simultaneous set survives.
        status_nxt = (status & ~clr) | status_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= '0;
            irq    <= 1'b0;
        end else begin
            status <= status_nxt;
            irq    <= |status_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCTRL; i++) begin
                ctrl_r[i] <= '0;
            end
            wr_stb <= '0;
        end else begin
            wr_stb <= '0;
            if (wr_cyc && !stat_sel) begin
                ctrl_r[idx_q] <= bus_in;
                wr_stb[idx_q] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_dat = status;
        if (!stat_sel) begin
            rd_dat = ctrl_r[idx_q];
        end
    end

    assign bus_drv = rd_cyc;
    assign bus_out = rd_cyc ? rd_dat : 16'h0000;

    for (genvar g = 0; g < NCTRL; g++) begin : g_flat
        assign ctrl[16*g +: 16] = ctrl_r[g];
    end

endmodule
